reservation_station: RTL

- Out-of-order issue buffer for ALU and branch instructions, between decoder/issue logic and the combinational EX unit.
- Holds decoded instructions until both source operands are available, snooping two broadcast buses (ALU result, LSB result) for ROB-tagged values.
- Each cycle, dispatches one ready entry to EX through a registered output stage.

---
 rtl/reservation_station.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// Out-of-order issue buffer: holds ALU/branch ops until operands arrive on the CDBs, dispatches one per cycle.
// Optional oldest-first select via age matrix when RS_AGE_SELECT_EN is defined.
module reservation_station #(
  parameter int RS_SIZE    = 16,
  parameter int ROB_IDX_W  = 4,
  parameter int INSTR_ID_W = 6,
  parameter int WORD_W     = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  issue_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [WORD_W-1:0]     imm_in,
  input  logic [WORD_W-1:0]     pc_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic                  rs1_rdy_in,
  input  logic                  rs2_rdy_in,
  input  logic [WORD_W-1:0]     rs1_val_in,
  input  logic [WORD_W-1:0]     rs2_val_in,
  input  logic [ROB_IDX_W-1:0]  rs1_tag_in,
  input  logic [ROB_IDX_W-1:0]  rs2_tag_in,
  input  logic                  alu_cdb_en_in,
  input  logic [ROB_IDX_W-1:0]  alu_cdb_tag_in,
  input  logic [WORD_W-1:0]     alu_cdb_val_in,
  input  logic                  lsb_cdb_en_in,
  input  logic [ROB_IDX_W-1:0]  lsb_cdb_tag_in,
  input  logic [WORD_W-1:0]     lsb_cdb_val_in,
  output logic                  full_out,
  output logic                  rs_to_ex_en_out,
  output logic [INSTR_ID_W-1:0] instr_id_out,
  output logic [WORD_W-1:0]     imm_out,
  output logic [WORD_W-1:0]     pc_out,
  output logic [WORD_W-1:0]     rs1_out,
  output logic [WORD_W-1:0]     rs2_out,
  output logic [ROB_IDX_W-1:0]  rob_pos_out
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]    valid, q1_rdy, q2_rdy;
  logic [INSTR_ID_W-1:0] id      [RS_SIZE];
  logic [WORD_W-1:0]     imm     [RS_SIZE];
  logic [WORD_W-1:0]     pc      [RS_SIZE];
  logic [ROB_IDX_W-1:0]  rob_pos [RS_SIZE];
  logic [WORD_W-1:0]     v1      [RS_SIZE];
  logic [WORD_W-1:0]     v2      [RS_SIZE];
  logic [ROB_IDX_W-1:0]  t1      [RS_SIZE];
  logic [ROB_IDX_W-1:0]  t2      [RS_SIZE];

  logic [RS_SIZE-1:0] cand, elig;
  logic               has_sel, has_free;
  logic [IDX_W-1:0]   sel_idx, free_idx;

  // Returns {ready, value} after snooping both buses; ALU wins when both match.
  function automatic logic [WORD_W:0] snoop(input logic rdy, input logic [WORD_W-1:0] val,
                                            input logic [ROB_IDX_W-1:0] tag);
    if (!rdy) begin
      if (alu_cdb_en_in && alu_cdb_tag_in == tag) return {1'b1, alu_cdb_val_in};
      if (lsb_cdb_en_in && lsb_cdb_tag_in == tag) return {1'b1, lsb_cdb_val_in};
    end
    return {rdy, val};
  endfunction

  assign full_out = &valid;
  assign cand     = valid & q1_rdy & q2_rdy;

`ifdef RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0] older [RS_SIZE];

  // A candidate is eligible only if no other candidate is older than it.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int unsigned j = 0; j < RS_SIZE; j++)
        if (cand[j] && older[j][i]) blocked = 1'b1;
      elig[i] = cand[i] && !blocked;
    end
  end
`else
  assign elig = cand;
`endif

  always_comb begin
    has_sel  = 1'b0;
    sel_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (elig[i] && !has_sel) begin
        has_sel = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!valid[i] && !has_free) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid           <= '0;
      q1_rdy          <= '0;
      q2_rdy          <= '0;
      rs_to_ex_en_out <= 1'b0;
      instr_id_out    <= '0;
      imm_out         <= '0;
      pc_out          <= '0;
      rs1_out         <= '0;
      rs2_out         <= '0;
      rob_pos_out     <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        id[i]      <= '0;
        imm[i]     <= '0;
        pc[i]      <= '0;
        rob_pos[i] <= '0;
        v1[i]      <= '0;
        v2[i]      <= '0;
        t1[i]      <= '0;
        t2[i]      <= '0;
`ifdef RS_AGE_SELECT_EN
        older[i]   <= '0;
`endif
      end
    end else if (!rdy_in) begin
      rs_to_ex_en_out <= 1'b0;
    end else if (clear_in) begin
      valid           <= '0;
      rs_to_ex_en_out <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (valid[i]) begin
          {q1_rdy[i], v1[i]} <= snoop(q1_rdy[i], v1[i], t1[i]);
          {q2_rdy[i], v2[i]} <= snoop(q2_rdy[i], v2[i], t2[i]);
        end
      end
      rs_to_ex_en_out <= has_sel;
      if (has_sel) begin
        instr_id_out   <= id[sel_idx];
        imm_out        <= imm[sel_idx];
        pc_out         <= pc[sel_idx];
        rs1_out        <= v1[sel_idx];
        rs2_out        <= v2[sel_idx];
        rob_pos_out    <= rob_pos[sel_idx];
        valid[sel_idx] <= 1'b0;
      end
      // The free slot is never the selected one, so both writes can coexist.
      if (issue_en_in && has_free) begin
        valid[free_idx]   <= 1'b1;
        id[free_idx]      <= instr_id_in;
        imm[free_idx]     <= imm_in;
        pc[free_idx]      <= pc_in;
        rob_pos[free_idx] <= rob_pos_in;
        t1[free_idx]      <= rs1_tag_in;
        t2[free_idx]      <= rs2_tag_in;
        {q1_rdy[free_idx], v1[free_idx]} <= snoop(rs1_rdy_in, rs1_val_in, rs1_tag_in);
        {q2_rdy[free_idx], v2[free_idx]} <= snoop(rs2_rdy_in, rs2_val_in, rs2_tag_in);
`ifdef RS_AGE_SELECT_EN
        for (int unsigned j = 0; j < RS_SIZE; j++)
          older[j][free_idx] <= valid[j];
        older[free_idx] <= '0;
`endif
      end
    end
  end

endmodule
